mul_div_unit: RTL



---
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative unsigned multiply / divide unit for the 8-bit datapath. It takes
// operands from the register file read ports and returns one result through
// the register file write port. One operand bit is handled per clock.
//
// Ports:
//   clk, rst      : clock; synchronous active-high reset
//   start         : request, sampled only while idle
//   op            : 00 MUL low, 01 MULH high, 10 DIV quotient, 11 REM remainder
//   a, b          : operand A / dividend, operand B / divisor
//   dest          : destination register index
//   busy          : high from the accepting edge until the unit is idle again
//   done          : one-cycle completion pulse (write-back cycle)
//   div_by_zero   : valid with done; DIV/REM with a zero divisor
//   we3, wa3, wd3 : register file write port (r0 is never written)
//   dbg_state     : current FSM state (0 idle, 1 run, 2 write-back)
//
// Handshake: start is a request that is taken on any rising edge where the
// unit is idle (busy=0); requests while busy are dropped, not queued. done
// marks the single cycle in which the write port carries the result.
module mul_div_unit #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [WIDTH-1:0]  wd3,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // acc holds {high half, low half}. Multiply: {partial product, remaining
  // multiplier bits}. Divide: {partial remainder, dividend bits / quotient}.
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Multiply step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole pair right; the carry of the
  // add becomes the new top bit.
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_next;

  // Divide step: shift the next dividend MSB into the remainder, trial
  // subtract the divisor, keep the difference when it does not borrow.
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH-1:0]    div_rem;
  logic [2*WIDTH-1:0]  div_next;

  logic [WIDTH-1:0]    result;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // When div_ge holds the true difference is below b, so its low WIDTH
    // bits are exact.
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Low half carries product-low or quotient; high half carries
    // product-high or remainder.
    case (op_q)
      2'b00:   result = acc_q[WIDTH-1:0];
      2'b01:   result = acc_q[2*WIDTH-1:WIDTH];
      2'b10:   result = acc_q[WIDTH-1:0];
      default: result = acc_q[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    op_d        = op_q;
    dest_d      = dest_q;
    cnt_d       = cnt_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    div_by_zero = 1'b0;
    we3         = 1'b0;
    wa3         = '0;
    wd3         = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = {{WIDTH{1'b0}}, a};
          b_d     = b;
          op_d    = op;
          dest_d  = dest;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        done        = 1'b1;
        we3         = (dest_q != '0);
        wa3         = dest_q;
        wd3         = result;
        div_by_zero = op_q[1] && (b_q == '0);
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule
